// File: rtl/dmem_pkg.sv
// Shared types, constants and address helpers for the data-memory responder.
package dmem_pkg;

  localparam int BE_W   = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word index of a byte address inside an array of 'depth' words.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int depth);
    return (addr >> 2) & (32'(depth) - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous SRAM: per-byte write enables and a registered read port.
// The read register can be cleared so that store and error responses return zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              clr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // Byte-lane write; the storage itself is never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read data, held until the next read or a clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rdata_r <= 32'h0000_0000;
    end else if (en && !we) begin
      rdata_r <= mem_r[idx];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles
// and returns read data or a write acknowledge over a valid/ready channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);
  // WAIT counts down from this value; unused when LATENCY is 1.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              accept_s, commit_s, handshake_s;

  logic              we_r, err_r;
  logic [AW-1:0]     idx_r;
  logic [WORD_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;

  logic              req_err_s;
  logic [AW-1:0]     req_idx_s;
  logic              cur_we_s, cur_err_s;
  logic [AW-1:0]     cur_idx_s;
  logic [WORD_W-1:0] cur_wdata_s;
  logic [BE_W-1:0]   cur_be_s;

  logic              arr_en_s, arr_clr_s;
  logic [WORD_W-1:0] arr_rdata_s;

  logic              ready_r, valid_r, resp_err_r;

  assign req_err_s = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign req_idx_s = AW'(word_index(req_addr, DEPTH));

  // Next-state logic: accept in IDLE, count down in WAIT, handshake in RESP.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_s  = RESP;
            commit_s = 1'b1;
          end else begin
            state_s = WAIT;
            cnt_s   = CNT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s  = RESP;
          commit_s = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s     = IDLE;
          handshake_s = 1'b1;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the commit happens on the accept edge, so use the live request.
  always_comb begin
    if (state_r == IDLE) begin
      cur_we_s    = req_we;
      cur_err_s   = req_err_s;
      cur_idx_s   = req_idx_s;
      cur_wdata_s = req_wdata;
      cur_be_s    = req_be;
    end else begin
      cur_we_s    = we_r;
      cur_err_s   = err_r;
      cur_idx_s   = idx_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
    end
  end

  // A commit under reset is dropped; stores and errors leave zero in the read register.
  assign arr_en_s  = commit_s && !cur_err_s && !reset;
  assign arr_clr_s = (commit_s && (cur_err_s || cur_we_s)) || handshake_s;

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Capture the accepted request for use at the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 32'h0000_0000;
      be_r    <= 4'h0;
    end else if (accept_s) begin
      we_r    <= req_we;
      err_r   <= req_err_s;
      idx_r   <= req_idx_s;
      wdata_r <= req_wdata;
      be_r    <= req_be;
    end else begin
      we_r    <= we_r;
      err_r   <= err_r;
      idx_r   <= idx_r;
      wdata_r <= wdata_r;
      be_r    <= be_r;
    end
  end

  // Registered handshake flags and error status, following the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      resp_err_r <= 1'b0;
    end else begin
      ready_r <= (state_s == IDLE);
      valid_r <= (state_s == RESP);
      if (commit_s) begin
        resp_err_r <= cur_err_s;
      end else if (handshake_s) begin
        resp_err_r <= 1'b0;
      end else begin
        resp_err_r <= resp_err_r;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (arr_en_s),
    .we    (cur_we_s),
    .be    (cur_be_s),
    .idx   (cur_idx_s),
    .wdata (cur_wdata_s),
    .clr   (arr_clr_s),
    .rdata (arr_rdata_s)
  );

  assign req_ready  = ready_r;
  assign resp_valid = valid_r;
  assign resp_rdata = arr_rdata_s;
  assign resp_err   = resp_err_r;

endmodule
